// File: rtl/multibyte_add_pkg.sv
// Shared definitions for the byte-serial wide adder: FSM state encoding and default width.
package multibyte_add_pkg;

  localparam int NBYTES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/carry_adder.sv
// 8-bit ripple-carry adder slice shared across all bytes of a wide operation.
module carry_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] s,
  output logic       c_out
);

  logic [8:0] carry;

  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = c_in;
    for (int i = 0; i < 8; i++) begin
      s[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[8];
  end

endmodule

// File: rtl/multibyte_add_seq.sv
// NBYTES-wide add (optionally subtract when SUB_ADDER_EN is defined) computed one byte per
// cycle, LSB first, through a single carry_adder slice with valid/ready on both sides.
module multibyte_add_seq
  import multibyte_add_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                c_in,
`ifdef SUB_ADDER_EN
  input  logic                sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] sum,
  output logic                c_out,
  output logic                overflow
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t             state, state_next;
  logic [8*NBYTES-1:0] a_reg, b_reg;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx;
  logic               last_byte;
  logic [7:0]         a_byte, b_byte, b_eff, add_s;
  logic               add_co;
`ifdef SUB_ADDER_EN
  logic               sub_reg;
`endif

  assign last_byte = (idx == IDX_W'(NBYTES - 1));

  // Byte selector: one NBYTES-way mux per operand, steered by the running index.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_byte = a_reg[i*8 +: 8];
        b_byte = b_reg[i*8 +: 8];
      end
    end
  end

`ifdef SUB_ADDER_EN
  assign b_eff = b_byte ^ {8{sub_reg}};
`else
  assign b_eff = b_byte;
`endif

  carry_adder u_adder (
    .a     (a_byte),
    .b     (b_eff),
    .c_in  (carry_reg),
    .s     (add_s),
    .c_out (add_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_byte) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operands are frozen at accept; sum bytes land one per RUN cycle and stay put through DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
`ifdef SUB_ADDER_EN
      sub_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= '0;
`ifdef SUB_ADDER_EN
            sub_reg   <= sub;
            carry_reg <= sub ? 1'b1 : c_in;
`else
            carry_reg <= c_in;
`endif
          end
        end
        RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (idx == IDX_W'(i)) sum[i*8 +: 8] <= add_s;
          end
          carry_reg <= add_co;
          idx       <= idx + 1'b1;
          if (last_byte) begin
            c_out    <= add_co;
            overflow <= (a_byte[7] == b_eff[7]) && (add_s[7] != a_byte[7]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench for multibyte_add_seq; build with SUB_ADDER_EN defined to cover subtraction.
module tb_multibyte_add_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  int tests    = 0;
  int failures = 0;
  int latency;
  logic [W-1:0] exp_sum;
  logic         exp_co, exp_ovf;

  always #5 clk = ~clk;

  multibyte_add_seq #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SUB_ADDER_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  // Whole-word reference: {overflow, c_out, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cin, input logic s);
    logic [W-1:0] beff;
    logic [W:0]   full;
    logic         cy, ovf;
    beff = s ? ~bv : bv;
    cy   = s ? 1'b1 : cin;
    full = {1'b0, av} + {1'b0, beff} + {{W{1'b0}}, cy};
    ovf  = (av[W-1] == beff[W-1]) && (full[W-1] != av[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic waitResult();
    latency = 0;
    while (out_valid !== 1'b1 && latency < 20) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cin, input logic s);
    int budget;
    budget = 0;
    while (in_ready !== 1'b1 && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    a = av; b = bv; c_in = cin; sub = s; in_valid = 1'b1;
    {exp_ovf, exp_co, exp_sum} = model(av, bv, cin, s);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    waitResult();
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".latency"},  64'(latency),   64'(NBYTES));
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".sum"},       64'(sum),       64'(exp_sum));
    check({tag, ".c_out"},     64'(c_out),     64'(exp_co));
    check({tag, ".overflow"},  64'(overflow),  64'(exp_ovf));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drop_valid"}, 64'(out_valid), 64'd0);
    check({tag, ".ready_back"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    logic [W-1:0] first_sum;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready",  64'(in_ready),  64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.sum",       64'(sum),       64'd0);
    check("rst.c_out",     64'(c_out),     64'd0);
    check("rst.overflow",  64'(overflow),  64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput("byte_carry");
    check("byte_carry.lit", 64'(sum), 64'h0000_0100);

    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    checkOutput("full_ripple");
    check("full_ripple.lit", 64'({c_out, sum}), 64'h1_0000_0000);

    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    checkOutput("signed_ovf");
    check("signed_ovf.lit", 64'({overflow, c_out, sum}), 64'h2_8000_0000);

    // Result held under backpressure while new operands wait at the input.
    applyStimulus(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0);
    first_sum = exp_sum;
    a = 32'h1111_2222; b = 32'h3333_4444; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp.out_valid", 64'(out_valid), 64'd1);
      check("bp.in_ready",  64'(in_ready),  64'd0);
      check("bp.sum",       64'(sum),       64'(first_sum));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.released",  64'(out_valid), 64'd0);
    check("bp.idle",      64'(in_ready),  64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    {exp_ovf, exp_co, exp_sum} = model(32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0);
    waitResult();
    checkOutput("bp_second");

    // Reset lands after two bytes have been computed.
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort.in_ready",  64'(in_ready),  64'd1);
    check("abort.out_valid", 64'(out_valid), 64'd0);
    check("abort.sum",       64'(sum),       64'd0);
    check("abort.c_out",     64'(c_out),     64'd0);
    repeat (6) @(posedge clk);
    #1;
    check("abort.no_result", 64'(out_valid), 64'd0);
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    checkOutput("after_abort");
    check("after_abort.lit", 64'(sum), 64'h2345_6789);

`ifdef SUB_ADDER_EN
    applyStimulus(32'd5, 32'd7, 1'b0, 1'b1);
    checkOutput("sub_borrow");
    check("sub_borrow.lit", 64'({c_out, sum}), 64'h0_FFFF_FFFE);
    applyStimulus(32'd7, 32'd5, 1'b0, 1'b1);
    checkOutput("sub_noborrow");
    check("sub_noborrow.lit", 64'({c_out, sum}), 64'h1_0000_0002);
`endif

    for (int n = 0; n < 16; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
`ifdef SUB_ADDER_EN
      rs = 1'($urandom_range(1, 0));
`else
      rs = 1'b0;
`endif
      applyStimulus(ra, rb, rc, rs);
      checkOutput($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
